data_break_ctrl: RTL and testbench

- Single-cycle data-break (DMA) channel for the RK8E-class disk path.
- Holds a current-address (CA) and word-count (WC) pair loaded by the disk controller.
- Buffers one 12-bit word at a time and requests the processor's DB0/DB1 break cycles via data_break/to_disk. Each break moves one word between memory and the device.
- Sits between the disk controller (upstream) and the main state machine plus memory mux (downstream).

---
 rtl/data_break_ctrl_pkg.sv | 37 +++
 rtl/data_break_ctrl_counters.sv | 52 +++++
 rtl/data_break_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_data_break_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_break_ctrl_pkg.sv
// Shared definitions for the RK8E-class data-break channel: processor
// major-state codes, word/address widths and the CA increment helper.
package data_break_ctrl_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 15;
  localparam int MS_W   = 5;

  // Processor major-state codes as presented on the state bus.
  localparam logic [MS_W-1:0] MS_FETCH = 5'b00001;
  localparam logic [MS_W-1:0] MS_DB0   = 5'b01000;
  localparam logic [MS_W-1:0] MS_DB1   = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_REQ   = 3'd2,
    S_BRK0  = 3'd3,
    S_BRK1  = 3'd4,
    S_DRAIN = 3'd5,
    S_FIN   = 3'd6
  } dbc_state_e;

  // Advance a {field, addr} pair; with field_inc the carry out of the word
  // bits ripples into the field, otherwise only the low 12 bits wrap.
  function automatic logic [ADDR_W-1:0] ca_incr(input logic [ADDR_W-1:0] ca,
                                                input logic field_inc);
    logic [ADDR_W-1:0] r;
    if (field_inc) begin
      r = ca + 15'd1;
    end else begin
      r = {ca[14:12], ca[11:0] + 12'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/data_break_ctrl_counters.sv
// Current-address / word-count pair for the data-break channel.
module dbc_counters
  import data_break_ctrl_pkg::*;
#(
  parameter bit FIELD_INC = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] ca_in,
  input  logic [WORD_W-1:0] wc_in,
  output logic [ADDR_W-1:0] ca,
  output logic [WORD_W-1:0] wc,
  output logic              wc_zero,
  output logic              wc_last
);

  logic [ADDR_W-1:0] ca_q, ca_d;
  logic [WORD_W-1:0] wc_q, wc_d;

  // Load takes priority; an increment advances both counters together.
  always_comb begin
    ca_d = ca_q;
    wc_d = wc_q;
    if (load) begin
      ca_d = ca_in;
      wc_d = wc_in;
    end else if (inc) begin
      ca_d = ca_incr(ca_q, FIELD_INC);
      wc_d = wc_q + 12'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ca_q <= '0;
      wc_q <= '0;
    end else begin
      ca_q <= ca_d;
      wc_q <= wc_d;
    end
  end

  assign ca      = ca_q;
  assign wc      = wc_q;
  assign wc_zero = (wc_q == '0);
  // Set while the word in flight is the final one of the block.
  assign wc_last = (wc_q == '1);

endmodule

// File: rtl/data_break_ctrl.sv
// Single-cycle data-break channel: buffers one word, requests DB0/DB1
// break cycles and moves that word between memory and the disk device.
module data_break_ctrl
  import data_break_ctrl_pkg::*;
#(
  parameter bit FIELD_INC = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir_to_disk,
  input  logic [ADDR_W-1:0] ca_in,
  input  logic [WORD_W-1:0] wc_in,
  input  logic              abort,
  input  logic [WORD_W-1:0] dev_wdata,
  input  logic              dev_wvalid,
  output logic              dev_wready,
  output logic [WORD_W-1:0] dev_rdata,
  output logic              dev_rvalid,
  input  logic              dev_rready,
  input  logic [MS_W-1:0]   state,
  input  logic              break_in_prog,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              data_break,
  output logic              to_disk,
  output logic [ADDR_W-1:0] db_addr,
  output logic [WORD_W-1:0] db_wdata,
  output logic              db_we,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ca_out,
  output logic [WORD_W-1:0] wc_out
);

  dbc_state_e        fsm_q, fsm_d;
  logic              dir_q, dir_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              pend_q, pend_d;
  logic              load, inc;
  logic [ADDR_W-1:0] ca;
  logic [WORD_W-1:0] wc;
  logic              wc_zero, wc_last;

  logic              data_break_q, data_break_d;
  logic              to_disk_q, to_disk_d;
  logic [ADDR_W-1:0] db_addr_q, db_addr_d;
  logic [WORD_W-1:0] db_wdata_q, db_wdata_d;
  logic              db_we_q, db_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dev_wready_q, dev_wready_d;
  logic              dev_rvalid_q, dev_rvalid_d;
  logic [WORD_W-1:0] dev_rdata_q, dev_rdata_d;

  dbc_counters #(.FIELD_INC(FIELD_INC)) u_counters (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .inc     (inc),
    .ca_in   (ca_in),
    .wc_in   (wc_in),
    .ca      (ca),
    .wc      (wc),
    .wc_zero (wc_zero),
    .wc_last (wc_last)
  );

  // Next-state, buffer and output decode; outputs are computed from the
  // next state so the registered copies line up with the state they describe.
  always_comb begin
    fsm_d  = fsm_q;
    dir_d  = dir_q;
    buf_d  = buf_q;
    pend_d = pend_q;
    load   = 1'b0;
    inc    = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          load   = 1'b1;
          dir_d  = dir_to_disk;
          pend_d = 1'b0;
          fsm_d  = dir_to_disk ? S_REQ : S_FILL;
        end
      end
      S_FILL: begin
        if (abort) begin
          fsm_d = S_FIN;
        end else if (dev_wvalid) begin
          buf_d = dev_wdata;
          fsm_d = S_REQ;
        end
      end
      S_REQ: begin
        // Only a DB0 answering our own raised request starts a break.
        if (abort) begin
          fsm_d = S_FIN;
        end else if (data_break_q && (state == MS_DB0) && break_in_prog) begin
          fsm_d = S_BRK0;
        end
      end
      S_BRK0: begin
        pend_d = pend_q | abort;
        fsm_d  = S_BRK1;
      end
      S_BRK1: begin
        inc    = 1'b1;
        pend_d = pend_q | abort;
        if (dir_q) begin
          buf_d = mem_rdata;
          fsm_d = pend_d ? S_FIN : S_DRAIN;
        end else begin
          fsm_d = (pend_d || wc_last) ? S_FIN : S_FILL;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          fsm_d = S_FIN;
        end else if (dev_rready) begin
          fsm_d = wc_zero ? S_FIN : S_REQ;
        end
      end
      S_FIN:   fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase

    busy_d       = (fsm_d != S_IDLE) && (fsm_d != S_FIN);
    done_d       = (fsm_d == S_FIN);
    to_disk_d    = busy_d ? dir_d : 1'b0;
    // Request is raised one cycle after REQ is entered and drops on BRK0.
    data_break_d = (fsm_q == S_REQ) && (fsm_d == S_REQ);
    db_we_d      = (fsm_d == S_BRK0) && !dir_q;
    db_wdata_d   = db_we_d ? buf_q : '0;
    db_addr_d    = (fsm_d == S_BRK0) ? ca : '0;
    dev_wready_d = (fsm_d == S_FILL);
    dev_rvalid_d = (fsm_d == S_DRAIN);
    dev_rdata_d  = dev_rvalid_d ? buf_d : '0;
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= S_IDLE;
      dir_q        <= 1'b0;
      buf_q        <= '0;
      pend_q       <= 1'b0;
      data_break_q <= 1'b0;
      to_disk_q    <= 1'b0;
      db_addr_q    <= '0;
      db_wdata_q   <= '0;
      db_we_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dev_wready_q <= 1'b0;
      dev_rvalid_q <= 1'b0;
      dev_rdata_q  <= '0;
    end else begin
      fsm_q        <= fsm_d;
      dir_q        <= dir_d;
      buf_q        <= buf_d;
      pend_q       <= pend_d;
      data_break_q <= data_break_d;
      to_disk_q    <= to_disk_d;
      db_addr_q    <= db_addr_d;
      db_wdata_q   <= db_wdata_d;
      db_we_q      <= db_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dev_wready_q <= dev_wready_d;
      dev_rvalid_q <= dev_rvalid_d;
      dev_rdata_q  <= dev_rdata_d;
    end
  end

  assign data_break = data_break_q;
  assign to_disk    = to_disk_q;
  assign db_addr    = db_addr_q;
  assign db_wdata   = db_wdata_q;
  assign db_we      = db_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dev_wready = dev_wready_q;
  assign dev_rvalid = dev_rvalid_q;
  assign dev_rdata  = dev_rdata_q;
  assign ca_out     = ca;
  assign wc_out     = wc;

endmodule

// File: tb/tb_data_break_ctrl.sv
// Self-checking bench for data_break_ctrl: a processor model answers break
// requests, a device model feeds words, scoreboards check memory writes.
module tb_data_break_ctrl;
  import data_break_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, start = 1'b0, dir_to_disk = 1'b0, abort = 1'b0;
  logic [14:0] ca_in = '0;
  logic [11:0] wc_in = '0, dev_wdata = '0, mem_rdata = '0;
  logic        dev_wvalid = 1'b0, dev_rready = 1'b0, break_in_prog = 1'b0;
  logic [4:0]  state_in = MS_FETCH;

  logic        dev_wready, dev_rvalid, data_break, to_disk, db_we, busy, done;
  logic [11:0] dev_rdata, db_wdata, wc_out;
  logic [14:0] db_addr, ca_out;

  logic        u1_dev_wready, u1_dev_rvalid, u1_data_break, u1_to_disk, u1_db_we, u1_busy, u1_done;
  logic [11:0] u1_dev_rdata, u1_db_wdata, u1_wc_out;
  logic [14:0] u1_db_addr, u1_ca_out;

  data_break_ctrl #(.FIELD_INC(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .dir_to_disk(dir_to_disk),
    .ca_in(ca_in), .wc_in(wc_in), .abort(abort),
    .dev_wdata(dev_wdata), .dev_wvalid(dev_wvalid), .dev_wready(dev_wready),
    .dev_rdata(dev_rdata), .dev_rvalid(dev_rvalid), .dev_rready(dev_rready),
    .state(state_in), .break_in_prog(break_in_prog), .mem_rdata(mem_rdata),
    .data_break(data_break), .to_disk(to_disk), .db_addr(db_addr),
    .db_wdata(db_wdata), .db_we(db_we), .busy(busy), .done(done),
    .ca_out(ca_out), .wc_out(wc_out)
  );

  data_break_ctrl #(.FIELD_INC(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .start(start), .dir_to_disk(dir_to_disk),
    .ca_in(ca_in), .wc_in(wc_in), .abort(abort),
    .dev_wdata(dev_wdata), .dev_wvalid(dev_wvalid), .dev_wready(u1_dev_wready),
    .dev_rdata(u1_dev_rdata), .dev_rvalid(u1_dev_rvalid), .dev_rready(dev_rready),
    .state(state_in), .break_in_prog(break_in_prog), .mem_rdata(mem_rdata),
    .data_break(u1_data_break), .to_disk(u1_to_disk), .db_addr(u1_db_addr),
    .db_wdata(u1_db_wdata), .db_we(u1_db_we), .busy(u1_busy), .done(u1_done),
    .ca_out(u1_ca_out), .wc_out(u1_wc_out)
  );

  typedef struct {
    logic [14:0] addr;
    logic [11:0] data;
  } wr_t;

  int          tests = 0, fails = 0;
  int          done_cnt = 0, we_cnt = 0;
  wr_t         exp_q[$], exp1_q[$];
  logic [11:0] dev_q[$], rd_q[$];
  bit          proc_en = 1'b0, chk1 = 1'b0, acc_prev = 1'b0;
  wr_t         e0, e1;
  logic [11:0] r0;

  // Processor model: DB0 then DB1, two cycles after seeing a request.
  initial begin
    forever begin
      @(negedge clk);
      if (proc_en && data_break) begin
        repeat (2) @(negedge clk);
        state_in = MS_DB0; break_in_prog = 1'b1;
        @(negedge clk);
        state_in = MS_DB1;
        @(negedge clk);
        state_in = MS_FETCH; break_in_prog = 1'b0;
      end
    end
  end

  // Device model: presents queued words, pops after each accepted one.
  initial begin
    forever begin
      @(negedge clk);
      if (acc_prev) void'(dev_q.pop_front());
      if (dev_q.size() > 0) begin
        dev_wvalid = 1'b1; dev_wdata = dev_q[0];
      end else begin
        dev_wvalid = 1'b0;
      end
      acc_prev = dev_wvalid && dev_wready;
    end
  end

  // Scoreboard monitors, sampled mid-low-phase.
  always @(negedge clk) begin
    #2;
    if (done) done_cnt++;
    if (db_we) begin
      we_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: addr=%o data=%o, required no write", db_addr, db_wdata);
      end else begin
        e0 = exp_q.pop_front();
        if (db_addr !== e0.addr || db_wdata !== e0.data) begin
          fails++;
          $display("FAIL wr: addr=%o data=%o, required addr=%o data=%o", db_addr, db_wdata, e0.addr, e0.data);
        end
      end
    end
    if (chk1 && u1_db_we) begin
      tests++;
      if (exp1_q.size() == 0) begin
        fails++;
        $display("FAIL wr_nf_unexpected: addr=%o, required no write", u1_db_addr);
      end else begin
        e1 = exp1_q.pop_front();
        if (u1_db_addr !== e1.addr || u1_db_wdata !== e1.data) begin
          fails++;
          $display("FAIL wr_nf: addr=%o data=%o, required addr=%o data=%o", u1_db_addr, u1_db_wdata, e1.addr, e1.data);
        end
      end
    end
    if (dev_rvalid && dev_rready) begin
      tests++;
      if (rd_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: data=%o, required no word", dev_rdata);
      end else begin
        r0 = rd_q.pop_front();
        if (dev_rdata !== r0) begin
          fails++;
          $display("FAIL rd: data=%o, required %o", dev_rdata, r0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic dir, input logic [14:0] ca, input logic [11:0] wc);
    @(negedge clk);
    start = 1'b1; dir_to_disk = dir; ca_in = ca; wc_in = wc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string nm);
    int n = 0;
    while (!done && n < max) begin
      @(negedge clk); n++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1", nm, max);
    end
  endtask

  task automatic wait_sig(input int max, input string nm, input int which);
    int n = 0;
    logic s;
    s = (which == 0) ? data_break : (which == 1) ? dev_rvalid : db_we;
    while (!s && n < max) begin
      @(negedge clk); n++;
      s = (which == 0) ? data_break : (which == 1) ? dev_rvalid : db_we;
    end
    tests++;
    if (!s) begin
      fails++;
      $display("FAIL %s_timeout: signal low after %0d cycles, required high", nm, max);
    end
  endtask

  task automatic chk15(input string nm, input logic [14:0] got, input logic [14:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %o, required %o", nm, got, req);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk15("rst_busy", {14'd0, busy}, 15'd0);
    chk15("rst_data_break", {14'd0, data_break}, 15'd0);
    chk15("rst_ca", ca_out, 15'd0);
    chk15("rst_wc", {3'd0, wc_out}, 15'd0);
    chk15("rst_outs", {9'd0, done, db_we, dev_wready, dev_rvalid, to_disk, |db_addr}, 15'd0);
    reset = 1'b0;
    @(negedge clk);
    chk15("post_rst_busy", {14'd0, busy}, 15'd0);
  endtask

  task automatic test_dev_to_mem();
    int d0 = done_cnt;
    logic [11:0] w[3];
    w[0] = 12'o1111; w[1] = 12'o2222; w[2] = 12'o3333;
    for (int i = 0; i < 3; i++) begin
      dev_q.push_back(w[i]);
      exp_q.push_back('{addr: 15'o01000 + 15'(i), data: w[i]});
    end
    proc_en = 1'b1;
    do_start(1'b0, 15'o01000, 12'o7775);
    wait_done(300, "d2m");
    @(negedge clk);
    chk15("d2m_done_cnt", 15'(done_cnt - d0), 15'd1);
    chk15("d2m_ca", ca_out, 15'o01003);
    chk15("d2m_wc", {3'd0, wc_out}, 15'd0);
    chk15("d2m_pending", 15'(exp_q.size()), 15'd0);
    chk15("d2m_busy", {14'd0, busy}, 15'd0);
  endtask

  task automatic test_mem_to_dev();
    rd_q.push_back(12'o4321);
    mem_rdata = 12'o4321; dev_rready = 1'b0; proc_en = 1'b1;
    do_start(1'b1, 15'o20000, 12'o7777);
    wait_sig(100, "m2d_rvalid", 1);
    for (int i = 0; i < 5; i++) begin
      chk15("m2d_hold", {dev_rvalid, 2'd0, dev_rdata}, {1'b1, 2'd0, 12'o4321});
      @(negedge clk);
    end
    dev_rready = 1'b1;
    @(negedge clk);
    dev_rready = 1'b0;
    chk15("m2d_done", {14'd0, done}, 15'd1);
    chk15("m2d_ca", ca_out, 15'o20001);
    chk15("m2d_wc", {3'd0, wc_out}, 15'd0);
    chk15("m2d_pending", 15'(rd_q.size()), 15'd0);
    mem_rdata = '0;
  endtask

  task automatic test_wrap();
    dev_q.push_back(12'o5555); dev_q.push_back(12'o6666);
    exp_q.push_back('{addr: 15'o07777, data: 12'o5555});
    exp_q.push_back('{addr: 15'o10000, data: 12'o6666});
    exp1_q.push_back('{addr: 15'o07777, data: 12'o5555});
    exp1_q.push_back('{addr: 15'o00000, data: 12'o6666});
    chk1 = 1'b1;
    do_start(1'b0, 15'o07777, 12'o7776);
    wait_done(300, "wrap");
    @(negedge clk);
    chk1 = 1'b0;
    chk15("wrap_ca_fi1", ca_out, 15'o10001);
    chk15("wrap_ca_fi0", u1_ca_out, 15'o00001);
    chk15("wrap_pending", 15'(exp_q.size() + exp1_q.size()), 15'd0);
  endtask

  task automatic test_abort_req();
    int d0 = done_cnt;
    proc_en = 1'b0;
    do_start(1'b1, 15'o00400, 12'o7770);
    wait_sig(50, "abreq_db", 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk15("abreq_data_break", {14'd0, data_break}, 15'd0);
    chk15("abreq_done", {14'd0, done}, 15'd1);
    chk15("abreq_ca", ca_out, 15'o00400);
    chk15("abreq_wc", {3'd0, wc_out}, {3'd0, 12'o7770});
    @(negedge clk);
    chk15("abreq_done_cnt", 15'(done_cnt - d0), 15'd1);
    proc_en = 1'b1;
  endtask

  task automatic test_abort_brk0();
    dev_q.push_back(12'o7070);
    exp_q.push_back('{addr: 15'o03000, data: 12'o7070});
    proc_en = 1'b1;
    do_start(1'b0, 15'o03000, 12'o7770);
    wait_sig(100, "abbrk_we", 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk15("abbrk_done", {14'd0, done}, 15'd1);
    chk15("abbrk_ca", ca_out, 15'o03001);
    chk15("abbrk_wc", {3'd0, wc_out}, {3'd0, 12'o7771});
    @(negedge clk);
    chk15("abbrk_pending", 15'(exp_q.size()), 15'd0);
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int w0 = we_cnt;
    for (int i = 0; i < 4096; i++) begin
      dev_q.push_back(12'(i) ^ 12'o5252);
      exp_q.push_back('{addr: 15'(i), data: 12'(i) ^ 12'o5252});
    end
    proc_en = 1'b1;
    do_start(1'b0, 15'o00000, 12'o0000);
    while (we_cnt - w0 < 10) @(negedge clk);
    do_start(1'b0, 15'o05555, 12'o1234);
    @(negedge clk);
    chk15("b2b_busy_mid", {14'd0, busy}, 15'd1);
    chk15("b2b_no_reload", {3'd0, wc_out}, {3'd0, ca_out[11:0]});
    wait_done(60000, "b2b");
    @(negedge clk);
    chk15("b2b_we_cnt", 15'(we_cnt - w0), 15'd4096);
    chk15("b2b_done_cnt", 15'(done_cnt - d0), 15'd1);
    chk15("b2b_ca", ca_out, 15'o10000);
    chk15("b2b_ca_fi0", u1_ca_out, 15'o00000);
    chk15("b2b_pending", 15'(exp_q.size()), 15'd0);
  endtask

  task automatic test_reset_in_req();
    proc_en = 1'b0;
    do_start(1'b1, 15'o01234, 12'o7000);
    wait_sig(50, "rstreq_db", 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk15("rstreq_data_break", {14'd0, data_break}, 15'd0);
    chk15("rstreq_busy", {14'd0, busy}, 15'd0);
    chk15("rstreq_ca", ca_out, 15'd0);
  endtask

  initial begin
    test_reset();
    test_dev_to_mem();
    repeat (3) @(negedge clk);
    test_mem_to_dev();
    repeat (3) @(negedge clk);
    test_wrap();
    repeat (3) @(negedge clk);
    test_abort_req();
    repeat (3) @(negedge clk);
    test_abort_brk0();
    repeat (3) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_reset_in_req();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
